// File: rtl/ws2812_encoder.sv
// WS2812 serial encoder: fetches one 24-bit GRB word per request and shapes it into
// 1.25 us bit cells; a frame-end request holds the line low for the latch period.
module ws2812_encoder #(
  parameter int BIT_CYCLES   = 15,
  parameter int T0H_CYCLES   = 4,
  parameter int T1H_CYCLES   = 8,
  parameter int LATCH_CYCLES = 3600
) (
  input  logic        clock_12mhz,
  input  logic        reset_n,
  input  logic        led_selected,
  input  logic [7:0]  led_counter,
  input  logic        done,
  output logic [7:0]  pixel_address,
  output logic        pixel_read,
  input  logic [23:0] pixel_data,
  output logic        led_data_out,
  output logic        encoder_finished,
  output logic        busy,
  output logic        overrun
);

  localparam logic [11:0] BIT_LAST   = 12'(BIT_CYCLES - 1);
  localparam logic [11:0] LATCH_LAST = 12'(LATCH_CYCLES - 1);
  localparam logic [11:0] T0H        = 12'(T0H_CYCLES);
  localparam logic [11:0] T1H        = 12'(T1H_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_SHIFT, S_FINISH, S_LATCH
  } state_t;

  state_t      state_q, state_d;
  logic        pend_valid_q, pend_valid_d;
  logic [7:0]  pend_index_q, pend_index_d;
  logic        latch_pend_q, latch_pend_d;
  logic [23:0] shift_q, shift_d;
  logic [4:0]  bit_q, bit_d;
  logic [11:0] cycle_q, cycle_d;
  logic [7:0]  addr_q, addr_d;
  logic        read_q, read_d;
  logic        led_q, led_d;
  logic        fin_q, fin_d;
  logic        busy_q, busy_d;
  logic        overrun_q, overrun_d;
  logic        bypass;
  logic [11:0] high_len;

  assign high_len = shift_q[bit_q] ? T1H : T0H;

  always_comb begin
    state_d      = state_q;
    pend_valid_d = pend_valid_q;
    pend_index_d = pend_index_q;
    latch_pend_d = latch_pend_q;
    shift_d      = shift_q;
    bit_d        = bit_q;
    cycle_d      = cycle_q;
    addr_d       = addr_q;
    overrun_d    = overrun_q;
    read_d       = 1'b0;
    led_d        = 1'b0;
    fin_d        = 1'b0;
    bypass       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pend_valid_q) begin
          state_d      = S_FETCH;
          addr_d       = pend_index_q;
          read_d       = 1'b1;
          pend_valid_d = 1'b0;
        end else if (led_selected) begin
          // Straight to FETCH so the first edge appears three cycles after the request.
          state_d = S_FETCH;
          addr_d  = led_counter;
          read_d  = 1'b1;
          bypass  = 1'b1;
        end else if (latch_pend_q) begin
          state_d      = S_LATCH;
          latch_pend_d = 1'b0;
          cycle_d      = 12'd0;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        state_d = S_SHIFT;
        shift_d = pixel_data;
        bit_d   = 5'd23;
        cycle_d = 12'd0;
        led_d   = 1'b1;
      end
      S_SHIFT: begin
        if (cycle_q == BIT_LAST) begin
          cycle_d = 12'd0;
          if (bit_q == 5'd0) begin
            state_d = S_FINISH;
            fin_d   = 1'b1;
          end else begin
            bit_d = bit_q - 5'd1;
            led_d = 1'b1;  // every bit cell opens high
          end
        end else begin
          cycle_d = cycle_q + 12'd1;
          led_d   = (cycle_q + 12'd1) < high_len;
        end
      end
      S_FINISH: state_d = S_IDLE;
      S_LATCH: begin
        if (cycle_q == LATCH_LAST) begin
          state_d = S_IDLE;
          cycle_d = 12'd0;
        end else begin
          cycle_d = cycle_q + 12'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // One-entry slot; IDLE frees it in the same cycle it is consumed.
    if (led_selected && !bypass) begin
      if (pend_valid_d) begin
        overrun_d = 1'b1;
      end else begin
        pend_valid_d = 1'b1;
        pend_index_d = led_counter;
      end
    end
    if (done) latch_pend_d = 1'b1;

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock_12mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      pend_valid_q <= 1'b0;
      pend_index_q <= 8'd0;
      latch_pend_q <= 1'b0;
      shift_q      <= 24'd0;
      bit_q        <= 5'd0;
      cycle_q      <= 12'd0;
      addr_q       <= 8'd0;
      read_q       <= 1'b0;
      led_q        <= 1'b0;
      fin_q        <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_index_q <= pend_index_d;
      latch_pend_q <= latch_pend_d;
      shift_q      <= shift_d;
      bit_q        <= bit_d;
      cycle_q      <= cycle_d;
      addr_q       <= addr_d;
      read_q       <= read_d;
      led_q        <= led_d;
      fin_q        <= fin_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
    end
  end

  assign pixel_address    = addr_q;
  assign pixel_read       = read_q;
  assign led_data_out     = led_q;
  assign encoder_finished = fin_q;
  assign busy             = busy_q;
  assign overrun          = overrun_q;

endmodule

// File: tb/tb_ws2812_encoder.sv
// Directed bench for ws2812_encoder: pixel waveforms, buffering, overrun, latch and reset.
module tb_ws2812_encoder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        led_selected;
  logic [7:0]  led_counter;
  logic        done;
  logic [7:0]  pixel_address;
  logic        pixel_read;
  logic [23:0] pixel_data = 24'd0;
  logic        led_data_out;
  logic        encoder_finished;
  logic        busy;
  logic        overrun;

  logic [23:0] pix [256];
  int checks = 0;
  int failures = 0;

  ws2812_encoder dut (
    .clock_12mhz     (clk),
    .reset_n         (reset_n),
    .led_selected    (led_selected),
    .led_counter     (led_counter),
    .done            (done),
    .pixel_address   (pixel_address),
    .pixel_read      (pixel_read),
    .pixel_data      (pixel_data),
    .led_data_out    (led_data_out),
    .encoder_finished(encoder_finished),
    .busy            (busy),
    .overrun         (overrun)
  );

  always #5 clk = ~clk;

  // Pixel buffer: data valid the cycle after the read strobe.
  always @(posedge clk) if (pixel_read) pixel_data <= pix[pixel_address];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge; ends after the LOAD cycle.
  task automatic start_pixel(input logic [7:0] idx, input logic done_now, input string tag);
    led_selected = 1'b1;
    led_counter  = idx;
    done         = done_now;
    @(negedge clk);
    led_selected = 1'b0;
    led_counter  = 8'hEE;
    done         = 1'b0;
    chk({tag, "_fetch_read"}, {31'd0, pixel_read}, 32'd1);
    chk({tag, "_fetch_addr"}, {24'd0, pixel_address}, {24'd0, idx});
    @(negedge clk);
    chk({tag, "_load_read"}, {31'd0, pixel_read}, 32'd0);
  endtask

  // Samples 360 SHIFT cycles bit by bit, optionally injecting requests at cycle k.
  task automatic check_pixel(input logic [23:0] w, input string tag, input int done_at,
                             input int s1_at, input logic [7:0] s1_idx,
                             input int s2_at, input logic [7:0] s2_idx);
    logic [14:0] got, exp;
    logic busy_ok;
    int k;
    busy_ok = 1'b1;
    for (int b = 23; b >= 0; b--) begin
      got = '0;
      exp = '0;
      for (int c = 0; c < 15; c++) begin
        @(negedge clk);
        k = (23 - b) * 15 + c;
        got[14-c] = led_data_out;
        exp[14-c] = (c < (w[b] ? 8 : 4));
        busy_ok   = busy_ok & busy;
        done         = (k == done_at);
        led_selected = (k == s1_at) || (k == s2_at);
        led_counter  = (k == s1_at) ? s1_idx : ((k == s2_at) ? s2_idx : 8'hEE);
      end
      chk($sformatf("%s_bit%0d", tag, b), {17'd0, got}, {17'd0, exp});
    end
    @(negedge clk);
    done = 1'b0;
    led_selected = 1'b0;
    chk({tag, "_finished"}, {31'd0, encoder_finished}, 32'd1);
    chk({tag, "_finish_line"}, {31'd0, led_data_out}, 32'd0);
    chk({tag, "_busy_shift"}, {31'd0, busy_ok}, 32'd1);
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_idle_fin"}, {31'd0, encoder_finished}, 32'd0);
  endtask

  task automatic check_latch(input string tag);
    int good;
    good = 0;
    for (int i = 0; i < 3600; i++) begin
      @(negedge clk);
      if (busy && !led_data_out) good++;
    end
    chk({tag, "_latch_cycles"}, good, 32'd3600);
    @(negedge clk);
    chk({tag, "_latch_end_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int quiet;
    pix[3]  = 24'h123456;
    pix[5]  = 24'hFF0000;
    pix[7]  = 24'hA5A5A5;
    pix[8]  = 24'h81007E;
    pix[10] = 24'hC33C0F;
    pix[11] = 24'h0FF081;
    pix[12] = 24'hFFFFFF;
    pix[20] = 24'hFFFFFF;
    pix[21] = 24'h00FF00;
    reset_n = 1'b0;
    led_selected = 1'b0;
    led_counter = 8'd0;
    done = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_outputs", {26'd0, pixel_address == 8'd0, pixel_read, led_data_out,
                        encoder_finished, busy, overrun}, 32'd32);
    reset_n = 1'b1;
    @(negedge clk);

    // Pixel 5 = FF0000
    start_pixel(8'd5, 1'b0, "p5");
    check_pixel(pix[5], "p5", -1, -1, 8'd0, -1, 8'd0);
    check_idle("p5");

    // Pixel 7 = A5A5A5
    start_pixel(8'd7, 1'b0, "p7");
    check_pixel(pix[7], "p7", -1, -1, 8'd0, -1, 8'd0);
    check_idle("p7");

    // Pixel 3 then done during its transmission: pixel first, then latch
    start_pixel(8'd3, 1'b0, "p3");
    check_pixel(pix[3], "p3", 7, -1, 8'd0, -1, 8'd0);
    check_idle("p3");
    check_latch("p3");

    // Three requests during one pixel: second buffered, third dropped
    start_pixel(8'd10, 1'b0, "p10");
    check_pixel(pix[10], "p10", -1, 50, 8'd11, 100, 8'd12);
    chk("ovr_set", {31'd0, overrun}, 32'd1);
    check_idle("p10");
    @(negedge clk);
    chk("p11_fetch_read", {31'd0, pixel_read}, 32'd1);
    chk("p11_fetch_addr", {24'd0, pixel_address}, 32'd11);
    @(negedge clk);
    check_pixel(pix[11], "p11", -1, -1, 8'd0, -1, 8'd0);
    quiet = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy && !pixel_read && !led_data_out) quiet++;
    end
    chk("drop_third_quiet", quiet, 32'd40);
    chk("ovr_sticky", {31'd0, overrun}, 32'd1);

    // Asynchronous reset in the middle of bit 12
    start_pixel(8'd20, 1'b0, "p20");
    repeat (171) @(negedge clk);
    chk("pre_rst_line", {31'd0, led_data_out}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_line", {31'd0, led_data_out}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_fin", {31'd0, encoder_finished}, 32'd0);
    chk("async_rst_ovr", {31'd0, overrun}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    quiet = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!busy && !pixel_read && !led_data_out && !encoder_finished) quiet++;
    end
    chk("post_rst_quiet", quiet, 32'd30);
    start_pixel(8'd21, 1'b0, "p21");
    check_pixel(pix[21], "p21", -1, -1, 8'd0, -1, 8'd0);
    check_idle("p21");

    // Request and done together from IDLE
    start_pixel(8'd8, 1'b1, "p8");
    check_pixel(pix[8], "p8", -1, -1, 8'd0, -1, 8'd0);
    check_idle("p8");
    check_latch("p8");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
